// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : light_pkg
//  Description : Shared state encoding, key codes and default timing for the
//                light keypad front end.
//  Revision    : 1.0
// ============================================================================
package light_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_AUTH  = 2'd2,
        S_LOCK  = 2'd3
    } light_state_t;

    localparam logic [3:0]  c_key_clear               = 4'hF;
    localparam logic [15:0] c_default_pin             = 16'h1234;
    localparam int          c_default_max_attempts    = 3;
    localparam int          c_default_auth_cycles     = 100;
    localparam int          c_default_lock_cycles     = 50;
    localparam int          c_default_debounce_cycles = 4;

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/light_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : light_debounce
//  Description : Two-flop synchronizer, debounce counter and rising-edge pulse
//                for one asynchronous push-button.
//  Revision    : 1.0
// ============================================================================
module light_debounce
    import light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);

    localparam int              c_cw      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_level_d;
    logic [c_cw-1:0] r_cnt;

    // Counter only runs while the synchronized sample differs from the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cw'(1);
            end
        end
    end

    assign pulse = r_level & ~r_level_d;

endmodule
`default_nettype wire

// File: rtl/light_keypad_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : light_keypad_frontend
//  Description : PIN entry with lockout, authorization window and debounced
//                on/off buttons gated by authorization.
//  Revision    : 1.0
// ============================================================================
module light_keypad_frontend
    import light_pkg::*;
#(
    parameter logic [15:0] PIN             = c_default_pin,
    parameter int          MAX_ATTEMPTS    = c_default_max_attempts,
    parameter int          AUTH_CYCLES     = c_default_auth_cycles,
    parameter int          LOCK_CYCLES     = c_default_lock_cycles,
    parameter int          DEBOUNCE_CYCLES = c_default_debounce_cycles
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       btn_on_raw,
    input  logic       btn_off_raw,
    output logic       keypad,
    output logic       onClick,
    output logic       offClick,
    output logic       locked,
    output logic [1:0] attempts
);

    localparam int              c_timer_max = (AUTH_CYCLES > LOCK_CYCLES) ? AUTH_CYCLES : LOCK_CYCLES;
    localparam int              c_tw        = $clog2(c_timer_max + 1);
    localparam logic [c_tw-1:0] c_auth_load = c_tw'(AUTH_CYCLES - 1);
    localparam logic [c_tw-1:0] c_lock_load = c_tw'(LOCK_CYCLES - 1);

    light_state_t    r_state,    w_state_nxt;
    logic [15:0]     r_entry,    w_entry_nxt;
    logic [2:0]      r_count,    w_count_nxt;
    logic [c_tw-1:0] r_timer,    w_timer_nxt;
    logic [1:0]      r_attempts, w_attempts_nxt;
    logic            r_keypad;
    logic            r_locked;
    logic            r_on_click;
    logic            r_off_click;

    logic            w_on_pulse;
    logic            w_off_pulse;
    logic            w_on_emit;
    logic            w_off_emit;
    logic            w_digit;
    logic            w_clear;
    logic [15:0]     w_entry_shift;

    light_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_on (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_on_raw),
        .pulse   (w_on_pulse)
    );

    light_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_off (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_off_raw),
        .pulse   (w_off_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_entry     <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_attempts  <= '0;
            r_keypad    <= 1'b0;
            r_locked    <= 1'b0;
            r_on_click  <= 1'b0;
            r_off_click <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_entry     <= w_entry_nxt;
            r_count     <= w_count_nxt;
            r_timer     <= w_timer_nxt;
            r_attempts  <= w_attempts_nxt;
            r_keypad    <= (w_state_nxt == S_AUTH);
            r_locked    <= (w_state_nxt == S_LOCK);
            r_on_click  <= w_on_emit;
            r_off_click <= w_off_emit;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_entry_nxt    = r_entry;
        w_count_nxt    = r_count;
        w_timer_nxt    = r_timer;
        w_attempts_nxt = r_attempts;
        w_digit        = key_valid && is_digit(key_code);
        w_clear        = key_valid && (key_code == c_key_clear);
        w_entry_shift  = {r_entry[11:0], key_code};
        // Simultaneous presses cancel each other rather than picking a winner.
        w_on_emit      = (r_state == S_AUTH) && w_on_pulse && !w_off_pulse;
        w_off_emit     = (r_state == S_AUTH) && w_off_pulse && !w_on_pulse;

        case (r_state)
            S_IDLE: begin
                if (w_digit) begin
                    w_entry_nxt = {12'h000, key_code};
                    w_count_nxt = 3'd1;
                    w_state_nxt = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (w_clear) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_digit) begin
                    if (r_count == 3'd3) begin
                        w_entry_nxt = '0;
                        w_count_nxt = '0;
                        if (w_entry_shift == PIN) begin
                            w_state_nxt    = S_AUTH;
                            w_attempts_nxt = '0;
                            w_timer_nxt    = c_auth_load;
                        end else if (int'(r_attempts) + 1 >= MAX_ATTEMPTS) begin
                            w_state_nxt    = S_LOCK;
                            w_attempts_nxt = '0;
                            w_timer_nxt    = c_lock_load;
                        end else begin
                            w_state_nxt    = S_IDLE;
                            w_attempts_nxt = r_attempts + 2'd1;
                        end
                    end else begin
                        w_entry_nxt = w_entry_shift;
                        w_count_nxt = r_count + 3'd1;
                    end
                end
            end
            S_AUTH: begin
                if (w_clear) begin
                    w_timer_nxt = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_on_emit || w_off_emit) begin
                    w_timer_nxt = c_auth_load;
                end else if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - c_tw'(1);
                end
            end
            S_LOCK: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - c_tw'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign keypad   = r_keypad;
    assign locked   = r_locked;
    assign onClick  = r_on_click;
    assign offClick = r_off_click;
    assign attempts = r_attempts;

endmodule
`default_nettype wire

// File: tb/tb_light_keypad_frontend.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_keypad_frontend
//  Description : Scoreboard bench for light_keypad_frontend (default params).
//  Revision    : 1.0
// ============================================================================
module tb_light_keypad_frontend;
    import light_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       btn_on_raw;
    logic       btn_off_raw;
    logic       keypad;
    logic       onClick;
    logic       offClick;
    logic       locked;
    logic [1:0] attempts;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entries: tag, cycle at which the output is due, expected vector
    // {keypad, locked, onClick, offClick, attempts[1:0]}.
    string      tag_q[$];
    int         cyc_q[$];
    logic [5:0] vec_q[$];

    light_keypad_frontend dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .btn_on_raw  (btn_on_raw),
        .btn_off_raw (btn_off_raw),
        .keypad      (keypad),
        .onClick     (onClick),
        .offClick    (offClick),
        .locked      (locked),
        .attempts    (attempts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    endtask

    always @(negedge clk) begin
        for (int i = cyc_q.size() - 1; i >= 0; i--) begin
            if (cyc_q[i] == cyc) begin
                check(tag_q[i], {keypad, locked, onClick, offClick, attempts}, vec_q[i]);
                tag_q.delete(i);
                cyc_q.delete(i);
                vec_q.delete(i);
            end
        end
    end

    function automatic logic [5:0] v(input logic kp, input logic lk, input logic on,
                                     input logic off, input logic [1:0] att);
        return {kp, lk, on, off, att};
    endfunction

    task automatic sb_push(input string tag, input int off, input logic [5:0] vec);
        tag_q.push_back(tag);
        cyc_q.push_back(cyc + off);
        vec_q.push_back(vec);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic key(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic pin(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b1;
        key_code    = 4'h1;
        btn_on_raw  = 1'b0;
        btn_off_raw = 1'b0;
        tick();
        tick();
        key_valid = 1'b0;
        key_code  = 4'h0;
        reset     = 1'b0;
        sb_push("reset_state", 0, v(0, 0, 0, 0, 2'd0));

        // Correct PIN, then the window expires after 100 cycles
        key(4'h1); key(4'h2); key(4'h3);
        sb_push("pre_auth", 0, v(0, 0, 0, 0, 2'd0));
        key(4'h4);
        sb_push("auth_rise", 0, v(1, 0, 0, 0, 2'd0));
        sb_push("auth_last", 99, v(1, 0, 0, 0, 2'd0));
        sb_push("auth_expire", 100, v(0, 0, 0, 0, 2'd0));
        wait_cyc(101);

        // Three wrong PINs lead to lockout
        for (int i = 1; i <= 2; i++) begin
            pin(4'h1, 4'h2, 4'h3, 4'h5);
            sb_push("wrong_pin", 0, v(0, 0, 0, 0, 2'(i)));
        end
        pin(4'h1, 4'h2, 4'h3, 4'h5);
        sb_push("lock_rise", 0, v(0, 1, 0, 0, 2'd0));
        sb_push("lock_last", 49, v(0, 1, 0, 0, 2'd0));
        sb_push("lock_end", 50, v(0, 0, 0, 0, 2'd0));
        pin(4'h1, 4'h2, 4'h3, 4'h4);
        sb_push("lock_ignores_pin", 0, v(0, 1, 0, 0, 2'd0));
        wait_cyc(50);
        pin(4'h1, 4'h2, 4'h3, 4'h4);
        sb_push("auth_after_lock", 0, v(1, 0, 0, 0, 2'd0));
        key(4'h5);
        sb_push("auth_digit_ignored", 0, v(1, 0, 0, 0, 2'd0));
        key(c_key_clear);
        sb_push("auth_clear", 0, v(0, 0, 0, 0, 2'd0));
        wait_cyc(3);

        // Off button while unauthorized, then clear mid-entry keeps attempts
        pin(4'h1, 4'h2, 4'h3, 4'h5);
        sb_push("one_wrong", 0, v(0, 0, 0, 0, 2'd1));
        btn_off_raw = 1'b1;
        for (int i = 1; i <= 15; i++) sb_push("off_unauth", i, v(0, 0, 0, 0, 2'd1));
        wait_cyc(15);
        btn_off_raw = 1'b0;
        wait_cyc(10);
        key(4'h1); key(4'h2); key(c_key_clear);
        sb_push("clear_keeps_attempts", 0, v(0, 0, 0, 0, 2'd1));
        pin(4'h1, 4'h2, 4'h3, 4'h4);
        sb_push("auth_after_clear", 0, v(1, 0, 0, 0, 2'd0));

        // Bouncy on-press in AUTH: one pulse 7 cycles after stable high, timer reloads
        btn_on_raw = 1'b1; tick();
        btn_on_raw = 1'b0; tick();
        btn_on_raw = 1'b1; tick();
        btn_on_raw = 1'b0; tick();
        btn_on_raw = 1'b1;
        for (int i = 1; i <= 106; i++)
            sb_push("on_press", i, v(1, 0, (i == 7), 0, 2'd0));
        sb_push("on_reload_expire", 107, v(0, 0, 0, 0, 2'd0));
        wait_cyc(20);
        btn_on_raw = 1'b0;
        wait_cyc(88);

        // Off-press in AUTH
        pin(4'h1, 4'h2, 4'h3, 4'h4);
        sb_push("auth_again", 0, v(1, 0, 0, 0, 2'd0));
        btn_off_raw = 1'b1;
        for (int i = 1; i <= 20; i++)
            sb_push("off_press", i, v(1, 0, 0, (i == 7), 2'd0));
        wait_cyc(12);
        btn_off_raw = 1'b0;
        wait_cyc(10);

        // Both buttons together: no pulses; then reset during AUTH
        btn_on_raw  = 1'b1;
        btn_off_raw = 1'b1;
        for (int i = 1; i <= 14; i++) sb_push("both_press", i, v(1, 0, 0, 0, 2'd0));
        wait_cyc(14);
        reset = 1'b1;
        tick();
        sb_push("reset_in_auth", 0, v(0, 0, 0, 0, 2'd0));
        reset       = 1'b0;
        btn_on_raw  = 1'b0;
        btn_off_raw = 1'b0;
        wait_cyc(10);
        pin(4'h1, 4'h2, 4'h3, 4'h4);
        sb_push("auth_after_reset", 0, v(1, 0, 0, 0, 2'd0));
        wait_cyc(5);

        for (int i = 0; i < tag_q.size(); i++) begin
            n_checks++;
            $display("FAIL %s: observed never-sampled expected %b (due cycle %0d)",
                     tag_q[i], vec_q[i], cyc_q[i]);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
